kw_frame_parser: RTL and testbench

KW_FRAME_PARSER -- requirements
Module: kw_frame_parser

---
 rtl/kw_frame_parser_pkg.sv | 17 +
 rtl/kw_frame_parser_strobe_edge_detect.sv | 34 +++
 rtl/kw_frame_parser.sv | 127 ++++++++++++
 tb/tb_kw_frame_parser.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kw_frame_parser_pkg.sv
// Shared definitions for the frequency-word frame parser: FSM encoding,
// command codes and timer width.
package kw_frame_parser_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GET_CMD  = 2'd1,
    GET_DATA = 2'd2,
    GET_CHK  = 2'd3
  } state_e;

  localparam logic [7:0] CMD_SET_KW   = 8'h01;
  localparam logic [7:0] CMD_SET_WAVE = 8'h02;

  localparam int TIMER_W = 17;

endpackage

// File: rtl/kw_frame_parser_strobe_edge_detect.sv
// Turns the UART receive-done strobe into a single-cycle accept pulse and
// captures the byte on the strobe's rising edge.
module strobe_edge_detect (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       strobe_i,
  input  logic [7:0] data_i,
  output logic       accept_o,
  output logic [7:0] data_o
);

  logic       strobe_q;
  logic       accept_q;
  logic [7:0] data_q;
  logic       rise;

  assign rise = strobe_i & ~strobe_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      strobe_q <= 1'b0;
      accept_q <= 1'b0;
      data_q   <= 8'h00;
    end else begin
      strobe_q <= strobe_i;
      accept_q <= rise;
      if (rise) data_q <= data_i;
    end
  end

  assign accept_o = accept_q;
  assign data_o   = data_q;

endmodule

// File: rtl/kw_frame_parser.sv
// Frame parser: HEADER CMD D3 D2 D1 D0 CHK -> frequency word / wave select.
// Define FRAME_TIMEOUT_EN to add the inter-byte timeout.
//
// state    | meaning
// IDLE     | hunting for HEADER, other bytes dropped
// GET_CMD  | next byte is the command
// GET_DATA | shifting D3..D0 into the shadow register
// GET_CHK  | next byte is the checksum; commit or reject
module kw_frame_parser
  import kw_frame_parser_pkg::*;
#(
  parameter logic [7:0]  HEADER      = 8'hAA,
  parameter logic [31:0] KW_RESET    = 32'd85899,
  parameter int          TIMEOUT_CYC = 50000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  RX_Data,
  input  logic        RX_Done_Sig,
  output logic [31:0] KW_Out,
  output logic [1:0]  Wave_Sel,
  output logic        KW_Valid,
  output logic        Frame_Err,
  output logic [7:0]  Err_Cnt
);

  logic       byte_vld;
  logic [7:0] byte_val;

  strobe_edge_detect u_edge (
    .clk_i    (CLK),
    .rst_i    (RST),
    .strobe_i (RX_Done_Sig),
    .data_i   (RX_Data),
    .accept_o (byte_vld),
    .data_o   (byte_val)
  );

  state_e      state_q;
  logic [7:0]  cmd_q;
  logic [7:0]  xor_q;
  logic [1:0]  idx_q;
  logic [31:0] shadow_q;
  logic [31:0] kw_q;
  logic [1:0]  wave_q;
  logic        kw_valid_q;
  logic        frame_err_q;
  logic [7:0]  err_cnt_q;
  logic        timeout;

`ifdef FRAME_TIMEOUT_EN
  logic [TIMER_W-1:0] timer_q;

  // An accepted byte in the expiry cycle wins over the timeout.
  assign timeout = (state_q != IDLE) && !byte_vld &&
                   (timer_q == TIMER_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge CLK) begin
    if (RST || state_q == IDLE || byte_vld || timeout) timer_q <= '0;
    else                                                timer_q <= timer_q + 1'b1;
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      cmd_q       <= 8'h00;
      xor_q       <= 8'h00;
      idx_q       <= 2'd0;
      shadow_q    <= 32'h0;
      kw_q        <= KW_RESET;
      wave_q      <= 2'b00;
      kw_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_cnt_q   <= 8'h00;
    end else begin
      kw_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      if (timeout) begin
        state_q     <= IDLE;
        frame_err_q <= 1'b1;
        if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
      end else if (byte_vld) begin
        case (state_q)
          IDLE: begin
            if (byte_val == HEADER) state_q <= GET_CMD;
          end
          GET_CMD: begin
            cmd_q   <= byte_val;
            xor_q   <= byte_val;
            idx_q   <= 2'd0;
            state_q <= GET_DATA;
          end
          GET_DATA: begin
            shadow_q <= {shadow_q[23:0], byte_val};
            xor_q    <= xor_q ^ byte_val;
            idx_q    <= idx_q + 2'd1;
            if (idx_q == 2'd3) state_q <= GET_CHK;
          end
          GET_CHK: begin
            state_q <= IDLE;
            if (byte_val == xor_q && cmd_q == CMD_SET_KW) begin
              kw_q       <= shadow_q;
              kw_valid_q <= 1'b1;
            end else if (byte_val == xor_q && cmd_q == CMD_SET_WAVE) begin
              wave_q     <= shadow_q[1:0];
              kw_valid_q <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
              if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign KW_Out    = kw_q;
  assign Wave_Sel  = wave_q;
  assign KW_Valid  = kw_valid_q;
  assign Frame_Err = frame_err_q;
  assign Err_Cnt   = err_cnt_q;

endmodule

// File: tb/tb_kw_frame_parser.sv
// Scoreboard bench for kw_frame_parser; timeout scenario is built only when
// FRAME_TIMEOUT_EN is defined (TIMEOUT_CYC is then 100).
module tb_kw_frame_parser;

`ifdef FRAME_TIMEOUT_EN
  localparam int TO_CYC = 100;
`else
  localparam int TO_CYC = 50000;
`endif
  localparam logic [31:0] KW_RST = 32'd85899;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  RX_Data;
  logic        RX_Done_Sig;
  logic [31:0] KW_Out;
  logic [1:0]  Wave_Sel;
  logic        KW_Valid;
  logic        Frame_Err;
  logic [7:0]  Err_Cnt;

  kw_frame_parser #(
    .HEADER      (8'hAA),
    .KW_RESET    (KW_RST),
    .TIMEOUT_CYC (TO_CYC)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .RX_Data     (RX_Data),
    .RX_Done_Sig (RX_Done_Sig),
    .KW_Out      (KW_Out),
    .Wave_Sel    (Wave_Sel),
    .KW_Valid    (KW_Valid),
    .Frame_Err   (Frame_Err),
    .Err_Cnt     (Err_Cnt)
  );

  always #5 CLK = ~CLK;

  // kind: 2'b01 commit (KW_Valid), 2'b10 reject (Frame_Err)
  typedef struct {
    logic [1:0]  kind;
    logic [31:0] kw;
    logic [1:0]  wave;
    logic [7:0]  ec;
    int          stamp;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];

  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;
  int n_valid = 0;
  int n_ferr = 0;
  int n_both = 0;

  logic [31:0] m_kw;
  logic [1:0]  m_wave;
  logic [7:0]  m_ec;
  logic [31:0] mid_kw;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (KW_Valid || Frame_Err) begin
      ev_t o;
      o.kind  = {Frame_Err, KW_Valid};
      o.kw    = KW_Out;
      o.wave  = Wave_Sel;
      o.ec    = Err_Cnt;
      o.stamp = cyc;
      obs_q.push_back(o);
    end
    if (KW_Valid) n_valid++;
    if (Frame_Err) n_ferr++;
    if (KW_Valid && Frame_Err) n_both++;
  end

  task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
    @(negedge CLK);
    RX_Data = b;
    RX_Done_Sig = 1'b1;
    repeat (hold) @(negedge CLK);
    RX_Done_Sig = 1'b0;
    repeat (gap) @(negedge CLK);
  endtask

  // Drives one frame, predicts its outcome and pushes it to the scoreboard.
  task automatic run_frame(input logic [7:0] cmd, input logic [31:0] d,
                           input logic [7:0] chk, input int hold);
    ev_t e;
    logic [7:0] x;
    x = cmd ^ d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0];
    e.kind = 2'b10;
    if (chk == x && cmd == 8'h01) begin
      m_kw = d;
      e.kind = 2'b01;
    end else if (chk == x && cmd == 8'h02) begin
      m_wave = d[1:0];
      e.kind = 2'b01;
    end else if (m_ec != 8'hFF) begin
      m_ec = m_ec + 8'd1;
    end
    send_byte(8'hAA, hold, 1);
    send_byte(cmd, hold, 1);
    send_byte(d[31:24], hold, 1);
    send_byte(d[23:16], hold, 1);
    send_byte(d[15:8], hold, 1);
    send_byte(d[7:0], hold, 1);
    mid_kw = KW_Out;
    @(negedge CLK);
    RX_Data = chk;
    RX_Done_Sig = 1'b1;
    e.stamp = cyc + 2;
    e.kw = m_kw;
    e.wave = m_wave;
    e.ec = m_ec;
    exp_q.push_back(e);
    for (int c = 1; c <= hold + 3; c++) begin
      @(negedge CLK);
      if (c >= hold) RX_Done_Sig = 1'b0;
    end
  endtask

  task automatic test_reset;
    RST = 1'b1;
    RX_Data = 8'h00;
    RX_Done_Sig = 1'b0;
    repeat (3) @(negedge CLK);
    n_cmp++; if (KW_Out !== KW_RST) begin n_mis++; $display("FAIL reset_kw got=%h exp=%h", KW_Out, KW_RST); end
    n_cmp++; if (Wave_Sel !== 2'b00) begin n_mis++; $display("FAIL reset_wave got=%b exp=00", Wave_Sel); end
    n_cmp++; if (KW_Valid !== 1'b0) begin n_mis++; $display("FAIL reset_valid got=%b exp=0", KW_Valid); end
    n_cmp++; if (Frame_Err !== 1'b0) begin n_mis++; $display("FAIL reset_err got=%b exp=0", Frame_Err); end
    n_cmp++; if (Err_Cnt !== 8'h00) begin n_mis++; $display("FAIL reset_errcnt got=%h exp=00", Err_Cnt); end
    RST = 1'b0;
    m_kw = KW_RST; m_wave = 2'b00; m_ec = 8'h00;
    @(negedge CLK);
  endtask

  task automatic test_set_kw;
    ev_t e, o;
    int n0;
    n0 = n_valid;
    // checksum 01^00^01^4F^8B = C4
    run_frame(8'h01, 32'h0001_4F8B, 8'hC4, 1);
    n_cmp++; if (mid_kw !== KW_RST) begin n_mis++; $display("FAIL kw_midframe got=%h exp=%h", mid_kw, KW_RST); end
    n_cmp++;
    if (obs_q.size() == 0) begin n_mis++; $display("FAIL set_kw no pulse got=0 exp=1"); exp_q.delete(); end
    else begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      if (o.kind !== e.kind || o.kw !== e.kw || o.wave !== e.wave || o.ec !== e.ec || o.stamp != e.stamp) begin
        n_mis++; $display("FAIL set_kw got kind=%b kw=%h wave=%b ec=%h t=%0d exp kind=%b kw=%h wave=%b ec=%h t=%0d",
                          o.kind, o.kw, o.wave, o.ec, o.stamp, e.kind, e.kw, e.wave, e.ec, e.stamp);
      end
    end
    n_cmp++; if (n_valid - n0 != 1) begin n_mis++; $display("FAIL set_kw_width got=%0d exp=1", n_valid - n0); end
  endtask

  task automatic test_set_wave;
    ev_t e, o;
    run_frame(8'h02, 32'h0000_0003, 8'h01, 1);
    n_cmp++;
    if (obs_q.size() == 0) begin n_mis++; $display("FAIL set_wave no pulse got=0 exp=1"); exp_q.delete(); end
    else begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      if (o.kind !== e.kind || o.kw !== e.kw || o.wave !== e.wave || o.ec !== e.ec || o.stamp != e.stamp) begin
        n_mis++; $display("FAIL set_wave got kind=%b kw=%h wave=%b ec=%h t=%0d exp kind=%b kw=%h wave=%b ec=%h t=%0d",
                          o.kind, o.kw, o.wave, o.ec, o.stamp, e.kind, e.kw, e.wave, e.ec, e.stamp);
      end
    end
  endtask

  task automatic test_bad_chk;
    ev_t e, o;
    run_frame(8'h01, 32'h0001_4F8B, 8'h00, 1);
    n_cmp++;
    if (obs_q.size() == 0) begin n_mis++; $display("FAIL bad_chk no pulse got=0 exp=1"); exp_q.delete(); end
    else begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      if (o.kind !== e.kind || o.kw !== e.kw || o.wave !== e.wave || o.ec !== e.ec || o.stamp != e.stamp) begin
        n_mis++; $display("FAIL bad_chk got kind=%b kw=%h wave=%b ec=%h t=%0d exp kind=%b kw=%h wave=%b ec=%h t=%0d",
                          o.kind, o.kw, o.wave, o.ec, o.stamp, e.kind, e.kw, e.wave, e.ec, e.stamp);
      end
    end
    n_cmp++; if (Err_Cnt !== 8'h01) begin n_mis++; $display("FAIL bad_chk_errcnt got=%h exp=01", Err_Cnt); end
  endtask

  task automatic test_long_strobe;
    ev_t e, o;
    int n0;
    n0 = n_valid;
    run_frame(8'h01, 32'h1234_5678, 8'h09, 5);
    n_cmp++; if (n_valid - n0 != 1) begin n_mis++; $display("FAIL long_strobe commits got=%0d exp=1", n_valid - n0); end
    n_cmp++;
    if (obs_q.size() == 0) begin n_mis++; $display("FAIL long_strobe no pulse got=0 exp=1"); exp_q.delete(); end
    else begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      if (o.kind !== e.kind || o.kw !== e.kw || o.wave !== e.wave || o.ec !== e.ec || o.stamp != e.stamp) begin
        n_mis++; $display("FAIL long_strobe got kind=%b kw=%h wave=%b ec=%h t=%0d exp kind=%b kw=%h wave=%b ec=%h t=%0d",
                          o.kind, o.kw, o.wave, o.ec, o.stamp, e.kind, e.kw, e.wave, e.ec, e.stamp);
      end
    end
  endtask

  task automatic test_header_in_data;
    ev_t e, o;
    run_frame(8'h01, 32'hAAAA_AAAA, 8'h01, 1);
    run_frame(8'h03, 32'h0000_0005, 8'h06, 1);
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (obs_q.size() == 0 || exp_q.size() == 0) begin
        n_mis++; $display("FAIL hdr_unknown[%0d] missing got=%0d exp=%0d", k, obs_q.size(), exp_q.size());
      end else begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        if (o.kind !== e.kind || o.kw !== e.kw || o.wave !== e.wave || o.ec !== e.ec || o.stamp != e.stamp) begin
          n_mis++; $display("FAIL hdr_unknown[%0d] got kind=%b kw=%h wave=%b ec=%h exp kind=%b kw=%h wave=%b ec=%h",
                            k, o.kind, o.kw, o.wave, o.ec, e.kind, e.kw, e.wave, e.ec);
        end
      end
    end
  endtask

`ifdef FRAME_TIMEOUT_EN
  task automatic test_timeout;
    ev_t e, o;
    bit got;
    send_byte(8'hAA, 1, 1);
    send_byte(8'h01, 1, 1);
    if (m_ec != 8'hFF) m_ec = m_ec + 8'd1;
    e.kind = 2'b10; e.kw = m_kw; e.wave = m_wave; e.ec = m_ec; e.stamp = 0;
    exp_q.push_back(e);
    got = 0;
    for (int c = 0; c < 130 && !got; c++) begin
      @(negedge CLK);
      if (obs_q.size() != 0) got = 1;
    end
    n_cmp++;
    if (!got) begin n_mis++; $display("FAIL timeout wait expired got=none exp=Frame_Err"); exp_q.delete(); end
    else begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      if (o.kind !== e.kind || o.kw !== e.kw || o.wave !== e.wave || o.ec !== e.ec) begin
        n_mis++; $display("FAIL timeout got kind=%b kw=%h wave=%b ec=%h exp kind=%b kw=%h wave=%b ec=%h",
                          o.kind, o.kw, o.wave, o.ec, e.kind, e.kw, e.wave, e.ec);
      end
    end
    run_frame(8'h02, 32'h0000_0001, 8'h03, 1);
    n_cmp++;
    if (obs_q.size() == 0) begin n_mis++; $display("FAIL after_timeout no pulse got=0 exp=1"); exp_q.delete(); end
    else begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      if (o.kind !== e.kind || o.wave !== e.wave || o.ec !== e.ec || o.stamp != e.stamp) begin
        n_mis++; $display("FAIL after_timeout got kind=%b wave=%b ec=%h exp kind=%b wave=%b ec=%h",
                          o.kind, o.wave, o.ec, e.kind, e.wave, e.ec);
      end
    end
  endtask
`endif

  task automatic test_saturate_and_reset;
    ev_t e, o;
    int bad = 0;
    int n0;
    for (int i = 0; i < 256; i++) begin
      run_frame(8'h01, i, 8'h5A ^ 8'(i) ^ 8'h01 ^ 8'h01, 1);
      if (obs_q.size() == 0 || exp_q.size() == 0) begin
        bad++; exp_q.delete(); obs_q.delete();
      end else begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        if (o.kind !== e.kind || o.kw !== e.kw || o.ec !== e.ec) bad++;
      end
    end
    n_cmp++; if (bad != 0) begin n_mis++; $display("FAIL bad_frames wrong events got=%0d exp=0", bad); end
    n_cmp++; if (Err_Cnt !== 8'hFF || m_ec !== 8'hFF) begin n_mis++; $display("FAIL errcnt_sat got=%h exp=%h", Err_Cnt, m_ec); end
    send_byte(8'hAA, 1, 1);
    send_byte(8'h01, 1, 1);
    send_byte(8'h00, 1, 0);
    n0 = n_ferr;
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    n_cmp++;
    if (KW_Out !== KW_RST || Wave_Sel !== 2'b00 || KW_Valid !== 1'b0 || Frame_Err !== 1'b0 || Err_Cnt !== 8'h00) begin
      n_mis++; $display("FAIL midframe_reset got kw=%h wave=%b v=%b e=%b ec=%h exp kw=%h wave=00 v=0 e=0 ec=00",
                        KW_Out, Wave_Sel, KW_Valid, Frame_Err, Err_Cnt, KW_RST);
    end
    RST = 1'b0;
    m_kw = KW_RST; m_wave = 2'b00; m_ec = 8'h00;
    repeat (3) @(negedge CLK);
    n_cmp++; if (n_ferr != n0 || obs_q.size() != 0) begin n_mis++; $display("FAIL reset_no_err got=%0d exp=0", n_ferr - n0); end
    obs_q.delete();
    run_frame(8'h02, 32'h0000_0002, 8'h00, 1);
    n_cmp++;
    if (obs_q.size() == 0) begin n_mis++; $display("FAIL post_reset no pulse got=0 exp=1"); exp_q.delete(); end
    else begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      if (o.kind !== e.kind || o.kw !== e.kw || o.wave !== e.wave || o.ec !== e.ec || o.stamp != e.stamp) begin
        n_mis++; $display("FAIL post_reset got kind=%b kw=%h wave=%b ec=%h exp kind=%b kw=%h wave=%b ec=%h",
                          o.kind, o.kw, o.wave, o.ec, e.kind, e.kw, e.wave, e.ec);
      end
    end
  endtask

  task automatic test_exclusive;
    n_cmp++; if (n_both != 0) begin n_mis++; $display("FAIL valid_err_overlap got=%0d exp=0", n_both); end
  endtask

  initial begin
    test_reset();
    test_set_kw();
    test_set_wave();
    test_bad_chk();
    test_long_strobe();
    test_header_in_data();
`ifdef FRAME_TIMEOUT_EN
    test_timeout();
`endif
    test_saturate_and_reset();
    test_exclusive();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
